hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the MIPS datapath.
- Accepts one operation at a time from the EX stage and runs multiply or multiply-accumulate over a fixed latency.
- Runs divide as a 32-iteration restoring loop.
- Asserts a stall to the pipeline when mfhi/mflo reads HI/LO while an operation is in flight.

Parameters:
MUL_LATENCY, 2, edges from Start acceptance to HI/LO write for MULT/MULTU/MADD/MSUB (legal range 1..8)

Ports:
Clk  input  1  clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only when Busy=0
Op  input  4  operation code (see package)
A  input  32  operand rs; captured when Start is accepted
B  input  32  operand rt; captured when Start is accepted
Flush  input  1  abort the in-flight operation (branch/exception squash)
HiLoRead  input  1  ID/EX holds an mfhi/mflo this cycle
Busy  output  1  operation in flight; new Start ignored
Done  output  1  one-cycle pulse; HI/LO just updated
Stall  output  1  HiLoRead & (Busy | Start-accepted-this-cycle)
Hi  output  32  HI register
Lo  output  32  LO register

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, Stall=0, FSM=IDLE. Reset takes effect from any state, including mid-operation; the partial result is discarded.
- Let E0 be the edge at which Start=1, Busy=0, Flush=0 and Op is legal. The result is written to HI/LO at edge E0+N. Done=1 during the cycle after E0+N. Busy=1 from E0 until edge E0+N.
- N values:
  - MTHI/MTLO: N=0. Written at E0, no Busy, Done next cycle. Only the selected register changes.
  - MULT/MULTU/MADD/MSUB: N=MUL_LATENCY.
  - DIV/DIVU: N=33.
  - Divide by zero: N=1.
- Illegal Op with Start: ignored. No Busy, no Done.
- Start while Busy: ignored. The pipeline must hold the request via Stall/hazard logic.
- FSM states:
  - IDLE -> MUL on mult-class op, MUL_LATENCY>1.
  - IDLE -> DIV on DIV/DIVU with B!=0.
  - IDLE -> DIVZ on DIV/DIVU with B==0.
  - MUL counts down, then writes the result and returns to IDLE. With MUL_LATENCY=1, IDLE writes at E0+1 via a one-cycle MUL state.
  - DIV runs 32 iterations, then goes to DFIX (sign fixup and write), then IDLE.
  - DIVZ writes and returns to IDLE.
- Arithmetic (64-bit {HI,LO}):
  - MULT: signed A*B.
  - MULTU: unsigned A*B.
  - MADD: {HI,LO} + signed A*B.
  - MSUB: {HI,LO} - signed A*B. Accumulate uses HI/LO as of the write edge; it is unchanged since E0. Wrap modulo 2^64.
- DIV/DIVU:
  - LO = quotient, HI = remainder.
  - Signed: operate on magnitudes. Quotient sign = sign(A)^sign(B); remainder sign = sign(A).
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divide by zero: HI=A, LO=0xFFFFFFFF, for both signed and unsigned.
- Flush:
  - Abort at the next edge and return to IDLE. HI/LO unchanged, no Done.
  - Flush with Start in the same cycle: Flush wins, no accept.
  - Flush on the write edge (E0+N): Flush wins, no write.
- Stall is combinational and has no registered latency. Hi/Lo outputs are register outputs.

Decomposition:
- Shared package hilo_pkg:
  - Op encodings: MULT=4'h0, MULTU=4'h1, MADD=4'h2, MSUB=4'h3, DIV=4'h4, DIVU=4'h5, MTHI=4'h6, MTLO=4'h7.
  - FSM state constants.
  - DIV_ITER=32.
- One sub-module, serial_divider32: restoring unsigned divide core with start/iteration count/quotient/remainder, one bit per cycle. The top level handles sign, fixup and divide-by-zero.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD(-3) B=5 -> Done 2 cycles after accept; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Busy high exactly 2 cycles.
- MTHI A=1, MTLO A=2, then MADD A=3 B=4 -> Hi=1, Lo=0x0000000E. Then MSUB A=0x10 B=1 -> Hi=0, Lo=0xFFFFFFFE (wrapped 64-bit).
- DIV A=0xFFFFFFF9(-7) B=2 -> Done at E0+33 cycle: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU same operands -> Lo=0x7FFFFFFC, Hi=1.
- DIVU A=7 B=0 -> Done after 1 edge, Hi=7, Lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start DIV, assert Flush at cycle 10 -> Busy drops next edge, no Done, Hi/Lo keep prior values. A second Start during Busy is ignored (no extra Done).
- HiLoRead=1 during a MULT in flight -> Stall=1 every Busy cycle, Stall=0 in the Done cycle. Reset asserted mid-DIV -> Hi=Lo=0, Busy=0 next cycle.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states, divide constants.
package hilo_pkg;

    typedef enum logic [3:0] {
        OpMult  = 4'h0,
        OpMultu = 4'h1,
        OpMadd  = 4'h2,
        OpMsub  = 4'h3,
        OpDiv   = 4'h4,
        OpDivu  = 4'h5,
        OpMthi  = 4'h6,
        OpMtlo  = 4'h7
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StDfix,
        StDivz
    } state_e;

    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned DivCntW  = 5;

    // Opcodes 8..15 are reserved and never accepted.
    function automatic logic op_legal(logic [3:0] op);
        return ~op[3];
    endfunction

    function automatic logic [31:0] cond_neg(logic [31:0] v, logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and the multiply/divide unit.
interface hilo_muldiv_unit_if;

    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hilo_read;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush, hilo_read,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hilo_read,
        output busy, done, stall, hi, lo
    );

endinterface

// File: rtl/serial_divider32.sv
// Restoring unsigned 32/32 divider producing one quotient bit per step.
module serial_divider32
    import hilo_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        last_o
);

    logic [31:0]        quo_q, quo_d;
    logic [31:0]        rem_q, rem_d;
    logic [31:0]        dsr_q, dsr_d;
    logic [DivCntW-1:0] cnt_q, cnt_d;
    logic [32:0]        shifted;
    logic [32:0]        trial;

    // Dividend bits shift out of quo_q's MSB while quotient bits shift into its LSB.
    assign shifted = {rem_q, quo_q[31]};
    assign trial   = shifted - {1'b0, dsr_q};

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dsr_d = dsr_q;
        cnt_d = cnt_q;
        if (start_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dsr_d = divisor_i;
            cnt_d = '0;
        end else if (step_i) begin
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign last_o      = (cnt_q == DivCntW'(DIV_ITER - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    hilo_muldiv_unit_if.slave bus_io
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        busy;
    logic        accept;
    logic        is_div_op;
    logic        div_signed_in;
    logic        div_start;
    logic        div_step;
    logic        div_last;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_signed_q;
    logic        neg_quo;
    logic        neg_rem;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;
    logic [63:0] mul_res;

    assign busy          = (state_q != StIdle);
    assign accept        = bus_io.start & ~busy & ~bus_io.flush & op_legal(bus_io.op);
    assign is_div_op     = (bus_io.op == OpDiv) || (bus_io.op == OpDivu);
    assign div_signed_in = (bus_io.op == OpDiv);
    assign div_start     = accept & is_div_op & (bus_io.b != '0);
    assign div_step      = (state_q == StDiv) & ~bus_io.flush;
    assign div_dividend  = cond_neg(bus_io.a, div_signed_in & bus_io.a[31]);
    assign div_divisor   = cond_neg(bus_io.b, div_signed_in & bus_io.b[31]);

    serial_divider32 u_div (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (div_start),
        .step_i      (div_step),
        .dividend_i  (div_dividend),
        .divisor_i   (div_divisor),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .last_o      (div_last)
    );

    // Low 64 bits of the sign-extended product equal the signed product modulo 2^64.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};
    assign acc    = {hi_q, lo_q};

    always_comb begin
        unique case (op_q)
            OpMultu: mul_res = prod_u;
            OpMadd:  mul_res = acc + prod_s;
            OpMsub:  mul_res = acc - prod_s;
            default: mul_res = prod_s;
        endcase
    end

    assign div_signed_q = (op_q == OpDiv);
    assign neg_quo      = div_signed_q & (a_q[31] ^ b_q[31]);
    assign neg_rem      = div_signed_q & a_q[31];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (bus_io.op)
                        OpMthi: begin
                            hi_d   = bus_io.a;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = bus_io.a;
                            done_d = 1'b1;
                        end
                        OpDiv, OpDivu: begin
                            state_d = (bus_io.b == '0) ? StDivz : StDiv;
                        end
                        default: begin
                            state_d = StMul;
                            cnt_d   = 3'(MUL_LATENCY - 1);
                        end
                    endcase
                end
            end
            StMul: begin
                if (bus_io.flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = mul_res;
                    done_d       = 1'b1;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDiv: begin
                if (bus_io.flush) begin
                    state_d = StIdle;
                end else if (div_last) begin
                    state_d = StDfix;
                end
            end
            StDfix: begin
                if (bus_io.flush) begin
                    state_d = StIdle;
                end else begin
                    lo_d    = cond_neg(div_quo, neg_quo);
                    hi_d    = cond_neg(div_rem, neg_rem);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StDivz: begin
                if (bus_io.flush) begin
                    state_d = StIdle;
                end else begin
                    hi_d    = a_q;
                    lo_d    = '1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            if (accept) begin
                op_q <= bus_io.op;
                a_q  <= bus_io.a;
                b_q  <= bus_io.b;
            end
        end
    end

    assign bus_io.busy  = busy;
    assign bus_io.done  = done_q;
    assign bus_io.stall = bus_io.hilo_read & (busy | accept);
    assign bus_io.hi    = hi_q;
    assign bus_io.lo    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed plus randomized bench for hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int unsigned MulLat = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if bus ();

    hilo_muldiv_unit #(
        .MUL_LATENCY (MulLat)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus_io  (bus)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] hi_m       = '0;
    logic [31:0] lo_m       = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected HI/LO and write latency straight from the architectural definition.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  output logic [31:0] eh, output logic [31:0] el, output int n);
        longint          sa, sb, sp;
        longint unsigned acc, up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sp  = sa * sb;
        up  = longint'({32'b0, a}) * longint'({32'b0, b});
        acc = {hi, lo};
        eh  = hi;
        el  = lo;
        n   = int'(MulLat);
        case (op)
            OpMult:  {eh, el} = sp;
            OpMultu: {eh, el} = up;
            OpMadd:  {eh, el} = acc + longint'(sp);
            OpMsub:  {eh, el} = acc - longint'(sp);
            OpDiv, OpDivu: begin
                if (b == 0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                    n  = 1;
                end else if (op == OpDiv) begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                    n  = 33;
                end else begin
                    el = a / b;
                    eh = a % b;
                    n  = 33;
                end
            end
            OpMthi: begin eh = a; n = 0; end
            OpMtlo: begin el = a; n = 0; end
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (bus.busy && guard < 100) begin
            tick();
            guard++;
        end
        check("idle_before_issue", 64'(bus.busy), 64'd0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] eh, el;
        int          n, k, busy_cnt;
        model(op, a, b, hi_m, lo_m, eh, el, n);
        issue(op, a, b);
        k        = 0;
        busy_cnt = 0;
        while (!bus.done && k < 60) begin
            if (bus.busy) busy_cnt++;
            tick();
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(n));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
        check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
        check({tag, "_lo"}, 64'(bus.lo), 64'(el));
        hi_m = eh;
        lo_m = el;
        tick();
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic count_done(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.done) dones++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb, eh, el;
        logic [3:0]  rop;
        int          n, dones;

        bus.start     = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        bus.hilo_read = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.hilo_read = 1'b1;
        #1;
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_stall", 64'(bus.stall), 64'd0);
        bus.hilo_read = 1'b0;
        tick();

        run_op("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mthi", OpMthi, 32'd1, 32'd0);
        run_op("mtlo", OpMtlo, 32'd2, 32'd0);
        run_op("madd", OpMadd, 32'd3, 32'd4);
        check("madd_const", {bus.hi, bus.lo}, 64'h0000_0001_0000_000E);
        run_op("msub", OpMsub, 32'h10, 32'd1);
        check("msub_const", {bus.hi, bus.lo}, 64'h0000_0000_FFFF_FFFE);
        run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", OpDivu, 32'hFFFF_FFF9, 32'd2);
        check("divu_const", {bus.hi, bus.lo}, 64'h0000_0001_7FFF_FFFC);
        run_op("divu_zero", OpDivu, 32'd7, 32'd0);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // Reserved opcode with a pending mfhi: nothing accepted, no stall.
        bus.hilo_read = 1'b1;
        bus.start     = 1'b1;
        bus.op        = 4'hA;
        bus.a         = 32'h1234;
        #1;
        check("illegal_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.start     = 1'b0;
        bus.hilo_read = 1'b0;
        check("illegal_busy", 64'(bus.busy), 64'd0);
        count_done(4, dones);
        check("illegal_done", 64'(dones), 64'd0);

        // Flush in the tenth cycle of a divide.
        issue(OpDiv, 32'd100, 32'd7);
        for (int k = 0; k < 9; k++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        count_done(40, dones);
        check("flush_no_done", 64'(dones), 64'd0);
        check("flush_keep", {bus.hi, bus.lo}, {hi_m, lo_m});

        // Second Start while busy is dropped.
        model(OpDivu, 32'd1000, 32'd3, hi_m, lo_m, eh, el, n);
        issue(OpDivu, 32'd1000, 32'd3);
        tick();
        bus.start = 1'b1;
        bus.op    = OpMthi;
        bus.a     = 32'hDEAD_BEEF;
        tick();
        bus.start = 1'b0;
        count_done(40, dones);
        check("busy_start_dones", 64'(dones), 64'd1);
        check("busy_start_result", {bus.hi, bus.lo}, {eh, el});
        hi_m = eh;
        lo_m = el;

        // Flush together with Start: Flush wins.
        bus.start = 1'b1;
        bus.op    = OpMult;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", 64'(bus.busy), 64'd0);
        count_done(4, dones);
        check("flush_start_done", 64'(dones), 64'd0);

        // Flush landing on the write edge suppresses the write.
        issue(OpMult, 32'd7, 32'd9);
        for (int k = 0; k < int'(MulLat) - 1; k++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_write_done", 64'(bus.done), 64'd0);
        check("flush_write_busy", 64'(bus.busy), 64'd0);
        check("flush_write_keep", {bus.hi, bus.lo}, {hi_m, lo_m});

        // Stall while a multiply is in flight, released in the Done cycle.
        model(OpMult, 32'd6, 32'd7, hi_m, lo_m, eh, el, n);
        bus.hilo_read = 1'b1;
        bus.start     = 1'b1;
        bus.op        = OpMult;
        bus.a         = 32'd6;
        bus.b         = 32'd7;
        #1;
        check("stall_accept", 64'(bus.stall), 64'd1);
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < int'(MulLat); k++) begin
            check("stall_busy", 64'(bus.stall), 64'd1);
            tick();
        end
        check("stall_done", 64'(bus.done), 64'd1);
        check("stall_release", 64'(bus.stall), 64'd0);
        check("stall_result", {bus.hi, bus.lo}, {eh, el});
        hi_m = eh;
        lo_m = el;
        bus.hilo_read = 1'b0;
        tick();

        // Reset in the middle of a divide.
        issue(OpDiv, 32'd12345, 32'd17);
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_hi", 64'(bus.hi), 64'd0);
        check("rst_mid_lo", 64'(bus.lo), 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        hi_m = '0;
        lo_m = '0;
        count_done(40, dones);
        check("rst_mid_done", 64'(dones), 64'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 5));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
